// File: rtl/text_blitter_if.sv
// Bus between the text blitter, its controller and the frame-buffer writer.
// START/BITMAP/origins flow toward the blitter; pixel and status signals flow out.
interface text_blitter_if;
    localparam int unsigned BITMAP_W = 210;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned C_W      = 3;

    logic                START;
    logic [BITMAP_W-1:0] BITMAP;
    logic                SELECT;
    logic [X_W-1:0]      X_ORIGIN;
    logic [Y_W-1:0]      Y_ORIGIN;
    logic [X_W-1:0]      X;
    logic [Y_W-1:0]      Y;
    logic [C_W-1:0]      COLOUR;
    logic                PLOT;
    logic                BUSY;
    logic                DONE;

    modport master (
        output START, BITMAP, X_ORIGIN, Y_ORIGIN,
        input  SELECT, X, Y, COLOUR, PLOT, BUSY, DONE
    );

    modport slave (
        input  START, BITMAP, X_ORIGIN, Y_ORIGIN,
        output SELECT, X, Y, COLOUR, PLOT, BUSY, DONE
    );
endinterface

// File: rtl/text_blitter.sv
// Draws a 6x35 text bitmap as one pixel per cycle at a screen origin.
// Define TEXT_BLITTER_SKIP_BG_EN to suppress PLOT for clear bits (transparent background).
module text_blitter #(
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic          CLOCK_50,
    input  logic          RESETN,
    text_blitter_if.slave bus
);
    localparam int unsigned ROWS  = 6;
    localparam int unsigned COLS  = 35;
    localparam int unsigned PIX   = ROWS * COLS;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 6;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 3;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, FINISH} state_t;

    state_t           state;
    logic [PIX-1:0]   bmp_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [X_W-1:0]   xo_q;
    logic [Y_W-1:0]   yo_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [C_W-1:0]   colour_q;
    logic             plot_q;
    logic             busy_q;
    logic             done_q;

    logic [ROW_W-1:0] nxt_row_c;
    logic [COL_W-1:0] nxt_col_c;
    logic             last_c;
    logic             first_bit_c;
    logic             nxt_bit_c;
    logic             first_plot_c;
    logic             nxt_plot_c;

    // Row r occupies [35r+34:35r] with column 0 in the MSB of the row.
    function automatic logic pix_bit(input logic [PIX-1:0]   b,
                                     input logic [ROW_W-1:0] r,
                                     input logic [COL_W-1:0] c);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(int'(r) * int'(COLS) + int'(COLS) - 1 - int'(c));
        return b[idx];
    endfunction

    // Next raster position and the bit/strobe for the pixel about to be presented.
    always_comb begin
        nxt_col_c    = col_q + COL_W'(1);
        nxt_row_c    = row_q;
        last_c       = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));
        if (col_q == COL_W'(COLS - 1)) begin
            nxt_col_c = '0;
            nxt_row_c = row_q + ROW_W'(1);
        end
        first_bit_c  = pix_bit(bus.BITMAP, '0, '0);
        nxt_bit_c    = pix_bit(bmp_q, nxt_row_c, nxt_col_c);
`ifdef TEXT_BLITTER_SKIP_BG_EN
        first_plot_c = first_bit_c;
        nxt_plot_c   = nxt_bit_c;
`else
        first_plot_c = 1'b1;
        nxt_plot_c   = 1'b1;
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESETN) begin
            state    <= IDLE;
            bmp_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            xo_q     <= '0;
            yo_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        xo_q   <= bus.X_ORIGIN;
                        yo_q   <= bus.Y_ORIGIN;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                // Pixel (0,0) comes straight from the bus as the bitmap is captured.
                LOAD: begin
                    bmp_q    <= bus.BITMAP;
                    row_q    <= '0;
                    col_q    <= '0;
                    x_q      <= xo_q;
                    y_q      <= yo_q;
                    colour_q <= first_bit_c ? FG_COLOUR : BG_COLOUR;
                    plot_q   <= first_plot_c;
                    state    <= DRAW;
                end
                DRAW: begin
                    if (last_c) begin
                        plot_q <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FINISH;
                    end else begin
                        row_q    <= nxt_row_c;
                        col_q    <= nxt_col_c;
                        x_q      <= xo_q + X_W'(nxt_col_c);
                        y_q      <= yo_q + Y_W'(nxt_row_c);
                        colour_q <= nxt_bit_c ? FG_COLOUR : BG_COLOUR;
                        plot_q   <= nxt_plot_c;
                    end
                end
                FINISH: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.SELECT = 1'b1;
    assign bus.X      = x_q;
    assign bus.Y      = y_q;
    assign bus.COLOUR = colour_q;
    assign bus.PLOT   = plot_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
endmodule

// File: tb/tb_text_blitter.sv
// Self-checking bench for text_blitter: table-driven draws, random draws against a
// raster model, plus reset-abort and back-to-back START sequences.
module tb_text_blitter;
    localparam int unsigned ROWS = 6;
    localparam int unsigned COLS = 35;
    localparam int unsigned PIX  = 210;
    localparam logic [2:0]  FG   = 3'b111;
    localparam logic [2:0]  BG   = 3'b000;
`ifdef TEXT_BLITTER_SKIP_BG_EN
    localparam bit SKIP_BG = 1'b1;
`else
    localparam bit SKIP_BG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #10 clk = ~clk;

    text_blitter_if bus();

    text_blitter #(.FG_COLOUR(FG), .BG_COLOUR(BG)) dut (
        .CLOCK_50 (clk),
        .RESETN   (rstn),
        .bus      (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic       obs_plot [PIX];
    logic [7:0] obs_x    [PIX];
    logic [6:0] obs_y    [PIX];
    logic [2:0] obs_col  [PIX];

    typedef struct {
        logic [7:0] xo;
        logic [6:0] yo;
        int         pat;
        int         poke;
        logic [7:0] fx;
        logic [6:0] fy;
        logic [7:0] lx;
        logic [6:0] ly;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [209:0] score_bitmap();
        logic [34:0] r0, r1, r2, r3, r4, r5;
        r0 = 35'b00111_00011_11000_11110_01111_10001_11110;
        r1 = 35'b01000_01000_01010_00101_00001_01000_00000;
        r2 = 35'b00110_01000_01010_00111_10001_11000_11100;
        r3 = 35'b00001_01000_01010_00101_00001_00001_00000;
        r4 = 35'b01110_00111_10001_10001_01111_10001_11110;
        r5 = 35'b00000_00000_00000_00000_00000_00000_00000;
        return {r5, r4, r3, r2, r1, r0};
    endfunction

    function automatic logic [209:0] pattern(input int p);
        logic [209:0] b;
        case (p)
            0:       b = score_bitmap();
            1:       b = '1;
            default: b = '0;
        endcase
        return b;
    endfunction

    function automatic logic [209:0] rand_bitmap();
        logic [209:0] b;
        b = '0;
        for (int i = 0; i < 7; i++) b[i*30 +: 30] = 30'($urandom);
        return b;
    endfunction

    // One complete draw: model the expected raster, run 250 cycles, compare.
    task automatic run_draw(input logic [7:0] xo, input logic [6:0] yo,
                            input logic [209:0] bmp, input int poke_at, input string name);
        logic       ex_plot [PIX];
        logic [7:0] ex_x    [PIX];
        logic [6:0] ex_y    [PIX];
        logic [2:0] ex_col  [PIX];
        logic [34:0] row;
        logic        b;
        int k, busy_cycles, done_at, done_cnt, bad, first_bad, n_obs, n_exp;
        logic [1:0] done_pb;

        n_exp = 0;
        for (int r = 0; r < int'(ROWS); r++) begin
            row = 35'(bmp >> (35 * r));
            for (int c = 0; c < int'(COLS); c++) begin
                k          = r * int'(COLS) + c;
                b          = row[34 - c];
                ex_x[k]    = 8'((int'(xo) + c) % 256);
                ex_y[k]    = 7'((int'(yo) + r) % 128);
                ex_col[k]  = b ? FG : BG;
                ex_plot[k] = SKIP_BG ? b : 1'b1;
                if (ex_plot[k]) n_exp++;
            end
        end

        @(negedge clk);
        bus.START    = 1'b1;
        bus.X_ORIGIN = xo;
        bus.Y_ORIGIN = yo;
        bus.BITMAP   = bmp;
        @(negedge clk);
        bus.START = 1'b0;
        chk({name, " load busy/plot"}, {bus.BUSY, bus.PLOT}, 2'b10);
        busy_cycles = bus.BUSY ? 1 : 0;
        done_at  = -1;
        done_cnt = 0;
        done_pb  = 2'b11;
        for (int c = 1; c <= 250; c++) begin
            @(negedge clk);
            if (bus.BUSY) busy_cycles++;
            if (bus.DONE) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    done_pb = {bus.PLOT, bus.BUSY};
                end
            end
            if (c <= int'(PIX)) begin
                obs_plot[c-1] = bus.PLOT;
                obs_x[c-1]    = bus.X;
                obs_y[c-1]    = bus.Y;
                obs_col[c-1]  = bus.COLOUR;
            end
            if (c == 1) begin
                bus.X_ORIGIN = ~xo;
                bus.Y_ORIGIN = ~yo;
                bus.BITMAP   = ~bmp;
            end
            bus.START = (c == poke_at);
        end
        bus.START = 1'b0;

        bad = 0;
        first_bad = 0;
        n_obs = 0;
        for (int i = 0; i < int'(PIX); i++) begin
            if (obs_plot[i] === 1'b1) n_obs++;
            if (obs_x[i] !== ex_x[i] || obs_y[i] !== ex_y[i] || obs_plot[i] !== ex_plot[i] ||
                (ex_plot[i] && obs_col[i] !== ex_col[i])) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s pixels: %0d wrong, first #%0d got x=%0d y=%0d c=%0d p=%0d, expected x=%0d y=%0d c=%0d p=%0d",
                     name, bad, first_bad, obs_x[first_bad], obs_y[first_bad], obs_col[first_bad],
                     obs_plot[first_bad], ex_x[first_bad], ex_y[first_bad], ex_col[first_bad],
                     ex_plot[first_bad]);
        end
        chk({name, " plot count"}, n_obs, n_exp);
        chk({name, " busy cycles"}, busy_cycles, 211);
        chk({name, " done count"}, done_cnt, 1);
        chk({name, " done cycle"}, done_at, 211);
        chk({name, " plot/busy at done"}, done_pb, 2'b00);
    endtask

    initial begin
        logic [209:0] bmp;
        logic [5:0]   r0_bits;
        int           cnt;
        int           dn;
        int           bz;

        rstn         = 1'b0;
        bus.START    = 1'b0;
        bus.BITMAP   = '0;
        bus.X_ORIGIN = '0;
        bus.Y_ORIGIN = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {bus.X, bus.Y, bus.COLOUR, bus.PLOT, bus.BUSY, bus.DONE}, 0);
        chk("reset select", bus.SELECT, 1'b1);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle busy", bus.BUSY, 1'b0);

        vecs[0] = '{xo: 8'd10,  yo: 7'd5,   pat: 0, poke: 100, fx: 8'd10,  fy: 7'd5,   lx: 8'd44,  ly: 7'd10};
        vecs[1] = '{xo: 8'd250, yo: 7'd125, pat: 1, poke: 0,   fx: 8'd250, fy: 7'd125, lx: 8'd28,  ly: 7'd2};
        vecs[2] = '{xo: 8'd0,   yo: 7'd0,   pat: 2, poke: 211, fx: 8'd0,   fy: 7'd0,   lx: 8'd34,  ly: 7'd5};
        vecs[3] = '{xo: 8'd221, yo: 7'd122, pat: 0, poke: 1,   fx: 8'd221, fy: 7'd122, lx: 8'd255, ly: 7'd127};
        vecs[4] = '{xo: 8'd255, yo: 7'd127, pat: 1, poke: 0,   fx: 8'd255, fy: 7'd127, lx: 8'd33,  ly: 7'd4};

        for (int i = 0; i < 5; i++) begin
            run_draw(vecs[i].xo, vecs[i].yo, pattern(vecs[i].pat), vecs[i].poke,
                     $sformatf("vec%0d", i));
            chk($sformatf("vec%0d first xy", i), {obs_x[0], obs_y[0]}, {vecs[i].fx, vecs[i].fy});
            chk($sformatf("vec%0d last xy", i), {obs_x[PIX-1], obs_y[PIX-1]}, {vecs[i].lx, vecs[i].ly});
            if (i == 0) begin
                r0_bits = 6'b001110;
                for (int c = 0; c < 6; c++) begin
                    chk($sformatf("score row0 col%0d", c),
                        obs_plot[c] ? {1'b1, obs_col[c]} : 4'b0000,
                        (SKIP_BG && !r0_bits[5-c]) ? 4'b0000 : {1'b1, r0_bits[5-c] ? FG : BG});
                end
            end
            if (i == 1) begin
                chk("wrap col6 x", obs_x[6], 8'd0);
                chk("wrap row3 y", obs_y[3*COLS], 7'd0);
            end
        end

        for (int i = 0; i < 4; i++) begin
            run_draw(8'($urandom), 7'($urandom), rand_bitmap(), int'($urandom_range(211, 1)),
                     $sformatf("rand%0d", i));
        end

        // Reset in the middle of a draw aborts it without DONE.
        @(negedge clk);
        bus.START    = 1'b1;
        bus.X_ORIGIN = 8'd30;
        bus.Y_ORIGIN = 7'd40;
        bus.BITMAP   = rand_bitmap();
        @(negedge clk);
        bus.START = 1'b0;
        repeat (50) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort outputs", {bus.PLOT, bus.BUSY, bus.DONE, bus.X, bus.Y}, 0);
        rstn = 1'b1;
        dn = 0;
        bz = 0;
        repeat (260) begin
            @(negedge clk);
            if (bus.DONE) dn++;
            if (bus.BUSY) bz++;
        end
        chk("abort no done", dn, 0);
        chk("abort stays idle", bz, 0);

        // START held high: second draw begins from the IDLE cycle after FINISH.
        bmp = '1;
        @(negedge clk);
        bus.START    = 1'b1;
        bus.X_ORIGIN = 8'd5;
        bus.Y_ORIGIN = 7'd6;
        bus.BITMAP   = bmp;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.DONE && cnt < 400);
        chk("hold done seen", bus.DONE, 1'b1);
        chk("hold done latency", cnt, 212);
        @(negedge clk);
        chk("hold idle gap busy", {bus.BUSY, bus.DONE}, 2'b00);
        @(negedge clk);
        chk("hold restart busy", bus.BUSY, 1'b1);
        bus.START = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.DONE && cnt < 400);
        chk("second done latency", cnt, 211);
        @(negedge clk);
        chk("select constant", bus.SELECT, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/text_blitter.md
TEXT_BLITTER -- requirements
Module: text_blitter

Interface
REQ-001 Parameter FG_COLOUR, default 3'b111: colour plotted for set bitmap bits.
REQ-002 Parameter BG_COLOUR, default 3'b000: colour plotted for clear bitmap bits.
REQ-003 CLOCK_50  input  1  system clock; all state updates on the rising edge.
REQ-004 RESETN  input  1  reset; synchronous, active-low.
REQ-005 START  input  1  draw request, sampled in IDLE only.
REQ-006 BITMAP  input  210  text bitmap of 6 rows x 35 columns; row r = BITMAP[35r+34:35r]; bit 35r+34 is column 0 (leftmost).
REQ-007 SELECT  output  1  text selector driven to the bitmap source; constant 1'b1 ("SCORE").
REQ-008 X_ORIGIN  input  8  screen column of the bitmap's top-left pixel.
REQ-009 Y_ORIGIN  input  7  screen row of the bitmap's top-left pixel.
REQ-010 X  output  8  pixel column to the frame-buffer writer.
REQ-011 Y  output  7  pixel row to the frame-buffer writer.
REQ-012 COLOUR  output  3  pixel colour.
REQ-013 PLOT  output  1  write strobe; X/Y/COLOUR valid while high.
REQ-014 BUSY  output  1  high from the cycle after START acceptance until DONE is asserted.
REQ-015 DONE  output  1  single-cycle pulse after the last pixel.

Function
REQ-016 FSM states: IDLE, LOAD, DRAW, FINISH; all outputs registered.
REQ-017 IDLE: START=1 on an edge moves to LOAD and captures X_ORIGIN/Y_ORIGIN.
REQ-018 LOAD: BITMAP is captured into an internal 210-bit register on the next edge; row counter and column counter cleared to 0; state goes to DRAW.
REQ-019 BITMAP and origin changes after capture do not affect the current draw.
REQ-020 DRAW: one pixel per cycle, column-major within row: col 0..34, then row+1; 210 consecutive cycles.
REQ-021 Per pixel: X = (Xo + col) mod 256, Y = (Yo + row) mod 128; COLOUR = FG_COLOUR if bit set, else BG_COLOUR.
REQ-022 First pixel (row 0, col 0) is on the outputs in the cycle following the LOAD edge; pixel (5,34) is the 210th.
REQ-023 After pixel (5,34): state FINISH for exactly one cycle with DONE=1, PLOT=0, BUSY=0; then IDLE.
REQ-024 START during LOAD/DRAW/FINISH is ignored, not queued; START held high in IDLE immediately after FINISH starts a new draw.
REQ-025 Outside DRAW: PLOT=0; X, Y, COLOUR hold their last values.
REQ-026 Counter wrap: col 34 -> 0 with row+1; row never exceeds 5.

Reset
REQ-027 RESETN=0 on an edge forces IDLE regardless of state, including mid-DRAW; the draw is aborted with no DONE.
REQ-028 Reset values: X=0, Y=0, COLOUR=0, PLOT=0, BUSY=0, DONE=0, counters=0, bitmap register=0; SELECT=1 at all times.

Configuration
REQ-029 Macro TEXT_BLITTER_SKIP_BG_EN: when defined, PLOT=0 for clear bitmap bits (transparent background); set bits are plotted unchanged.
REQ-030 Without TEXT_BLITTER_SKIP_BG_EN, all 210 pixels are plotted, clear bits with BG_COLOUR.
REQ-031 Either build: DRAW lasts exactly 210 cycles; X/Y advance every cycle.

Verification
REQ-032 Reset, then START with Xo=10, Yo=5, "SCORE" bitmap -> 210 PLOT cycles, first at (10,5), last at (44,10), DONE pulse next cycle, BUSY high 211 cycles (LOAD + 210 DRAW).
REQ-033 Row 0 of "SCORE" (35'b00111000111100011110011111000111110) -> COLOUR=3'b111 at X=12,13,14 and 3'b000 at X=10,11,15, Y=5.
REQ-034 Xo=250, Yo=125 -> col 6 plotted at X=0; row 3 plotted at Y=0 (mod wrap).
REQ-035 START pulsed at pixel 100 of a draw -> ignored; exactly one DONE; second START in IDLE -> full new draw.
REQ-036 RESETN low at pixel 50 -> next cycle PLOT=0, BUSY=0, X=Y=0; DONE never asserted.
REQ-037 TEXT_BLITTER_SKIP_BG_EN defined, all-ones bitmap -> 210 plots; all-zero bitmap -> 0 plots, DONE still after 210 DRAW cycles.
